// File: rtl/mc_main_control.sv
`default_nettype none
// ============================================================================
// Module   : mc_main_control
// Purpose  : Multi-cycle MIPS main control FSM with memory handshake and
//            retired-instruction counter.
// Revision : 1.0
// ============================================================================
module mc_main_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal_op,
    output logic             halted,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_HALT  = 6'b111111;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,  ST_DECODE = 4'd1,  ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,  ST_WB_MEM = 4'd4,  ST_MEMWR  = 4'd5,
        ST_EXEC_R = 4'd6,  ST_WB_R   = 4'd7,  ST_BRANCH = 4'd8,
        ST_EXEC_I = 4'd9,  ST_WB_I   = 4'd10, ST_JUMP   = 4'd11,
        ST_HALT   = 4'd12
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             r_is_store;
    logic             w_retire;

    logic       w_mem_req, w_mem_we, w_i_or_d, w_ir_write, w_pc_write;
    logic       w_branch, w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a;
    logic       w_illegal_op, w_halted;
    logic [1:0] w_pc_src, w_alu_src_b, w_alu_op;

    // Load/store choice is latched in DECODE so later opcode changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_count    <= '0;
            r_is_store <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_count <= r_count + CNT_W'(1);
            if (r_state == ST_DECODE)
                r_is_store <= (opcode == c_OP_SW);
        end
    end

    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_i_or_d     = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_branch     = 1'b0;
        w_pc_src     = 2'b00;
        w_reg_write  = 1'b0;
        w_reg_dst    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_illegal_op = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_alu_src_b = 2'b11;
                w_alu_op    = 2'b10;
                case (opcode)
                    c_OP_LW, c_OP_SW: w_next = ST_MEMADR;
                    c_OP_RTYPE:       w_next = ST_EXEC_R;
                    c_OP_BEQ:         w_next = ST_BRANCH;
                    c_OP_ADDI:        w_next = ST_EXEC_I;
                    c_OP_J:           w_next = ST_JUMP;
                    c_OP_HALT:        w_next = ST_HALT;
                    default: begin
                        w_illegal_op = 1'b1;
                        w_next       = ST_FETCH;
                    end
                endcase
            end
            ST_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = 2'b10;
                w_next      = r_is_store ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                w_mem_req = 1'b1;
                w_i_or_d  = 1'b1;
                if (mem_ready)
                    w_next = ST_WB_MEM;
            end
            ST_WB_MEM: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_retire     = 1'b1;
                w_next       = ST_FETCH;
            end
            ST_MEMWR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_i_or_d  = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = ST_FETCH;
                end
            end
            ST_EXEC_R: begin
                w_alu_src_a = 1'b1;
                w_next      = ST_WB_R;
            end
            ST_WB_R: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_retire    = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b01;
                w_branch    = 1'b1;
                w_pc_src    = 2'b01;
                w_retire    = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_EXEC_I: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = 2'b11;
                w_next      = ST_WB_I;
            end
            ST_WB_I: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_next      = ST_FETCH;
            end
            ST_JUMP: begin
                w_pc_write = 1'b1;
                w_pc_src   = 2'b10;
                w_retire   = 1'b1;
                w_next     = ST_FETCH;
            end
            ST_HALT: w_halted = 1'b1;
            default: w_next = ST_FETCH;
        endcase
    end

    // Every output is forced low during the reset cycle, even mid-access.
    assign mem_req     = w_mem_req    & ~rst;
    assign mem_we      = w_mem_we     & ~rst;
    assign i_or_d      = w_i_or_d     & ~rst;
    assign ir_write    = w_ir_write   & ~rst;
    assign pc_write    = w_pc_write   & ~rst;
    assign branch      = w_branch     & ~rst;
    assign pc_src      = rst ? 2'b00 : w_pc_src;
    assign reg_write   = w_reg_write  & ~rst;
    assign reg_dst     = w_reg_dst    & ~rst;
    assign mem_to_reg  = w_mem_to_reg & ~rst;
    assign alu_src_a   = w_alu_src_a  & ~rst;
    assign alu_src_b   = rst ? 2'b00 : w_alu_src_b;
    assign alu_op      = rst ? 2'b00 : w_alu_op;
    assign illegal_op  = w_illegal_op & ~rst;
    assign halted      = w_halted     & ~rst;
    assign state       = rst ? 4'd0 : r_state;
    assign instr_count = rst ? '0 : r_count;

endmodule
`default_nettype wire

// File: doc/mc_main_control.md
# mc_main_control

Multi-cycle main control FSM for the MIPS core. Sequences the shared datapath (single ALU, unified instruction/data memory, register file) through fetch, decode, execute, memory and writeback steps. Drives the `alu_op` field consumed by the ALU control unit, plus all datapath mux selects and write enables. Also handles the memory request/ready handshake and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: instruction[31:26] from the instruction register. Sampled only in DECODE.
- `mem_ready` in 1: memory completes the current access this cycle. Ignored while `mem_req`=0.
- `mem_req` out 1: memory access request. Held until `mem_ready`.
- `mem_we` out 1: write access. Valid only with `mem_req`.
- `i_or_d` out 1: address select. 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: unconditional PC load.
- `branch` out 1: PC load when the ALU zero flag is set.
- `pc_src` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `reg_write` out 1: register file write enable.
- `reg_dst` out 1: destination register. 0 = rt, 1 = rd.
- `mem_to_reg` out 1: writeback data. 0 = ALUOut, 1 = MDR.
- `alu_src_a` out 1: ALU A input. 0 = PC, 1 = rs.
- `alu_src_b` out 2: ALU B input. 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `alu_op` out 2: 00 = R-type (funct decodes), 01 = branch compare, 10 = address add, 11 = immediate op.
- `illegal_op` out 1: one-cycle pulse on an unknown opcode.
- `halted` out 1: core stopped.
- `state` out 4: current state, for debug.
- `instr_count` out CNT_W: count of retired instructions.

## Operation
- Opcodes:
  - R-type = 000000
  - lw = 100011
  - sw = 101011
  - beq = 000100
  - addi = 001000
  - j = 000010
  - halt = 111111
  - all others are illegal.
- Outputs are Moore, decoded from `state`. Any output not listed for a state is 0.
- States and transitions:
  - FETCH (0): `mem_req`, `alu_src_b`=01, `alu_op`=10. Stays in FETCH until `mem_ready`. In the `mem_ready` cycle, `ir_write` and `pc_write` are also asserted, then go to DECODE.
  - DECODE (1): `alu_src_b`=11, `alu_op`=10 (branch target into ALUOut). Next state by opcode:
    - lw/sw → MEMADR
    - R-type → EXEC_R
    - beq → BRANCH
    - addi → EXEC_I
    - j → JUMP
    - halt → HALT
    - illegal → FETCH, with `illegal_op`=1 in the DECODE cycle.
  - MEMADR (2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=10. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD (3): `mem_req`, `i_or_d`. Waits for `mem_ready`, then goes to WB_MEM.
  - WB_MEM (4): `reg_write`, `mem_to_reg`. Then FETCH.
  - MEMWR (5): `mem_req`, `mem_we`, `i_or_d`. Waits for `mem_ready`, then goes to FETCH.
  - EXEC_R (6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=00. Then WB_R.
  - WB_R (7): `reg_write`, `reg_dst`. Then FETCH.
  - BRANCH (8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `branch`, `pc_src`=01. Then FETCH.
  - EXEC_I (9): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11. Then WB_I.
  - WB_I (10): `reg_write` (`reg_dst`=0, `mem_to_reg`=0). Then FETCH.
  - JUMP (11): `pc_write`, `pc_src`=10. Then FETCH.
  - HALT (12): `halted`=1. Stays in HALT until `rst`.
- Encodings 13-15 are unreachable. If entered, the FSM goes to FETCH on the next edge with all outputs 0.
- `instr_count` increments by 1 on the edge that leaves any of these states towards FETCH: WB_MEM, MEMWR (on `mem_ready`), WB_R, BRANCH, WB_I, JUMP.
  - It does not increment on illegal opcodes or halt.
  - It wraps modulo 2^CNT_W.

## Timing
- Reset:
  - While `rst`=1, every output is 0, including `mem_req`.
  - On the reset edge, `state` ← FETCH and `instr_count` ← 0.
  - `mem_req`=1 on the first cycle after `rst` falls.
- Reset mid-operation takes priority over everything, including a pending `mem_ready`. An outstanding access is abandoned and `mem_req` drops in the `rst` cycle.
- Handshake:
  - The access completes in the cycle where `mem_req`=1 and `mem_ready`=1.
  - `mem_req`, `mem_we`, `i_or_d` and the address selects stay stable until completion.
  - `mem_ready` asserted in the same cycle as a new `mem_req` completes with zero wait.
- Latency with `mem_ready` tied high, in cycles from FETCH entry back to FETCH:
  - beq 3, j 3
  - R-type 4, addi 4, sw 4
  - lw 5
  - illegal 2
- Each wait cycle on `mem_ready` adds one cycle.
- `opcode` changes outside DECODE have no effect.

## Test plan
- Reset: hold `rst` 3 cycles with `mem_ready`=1 → all outputs 0 during reset. First post-reset cycle: `state`=0, `mem_req`=1, `instr_count`=0.
- R-type then addi, `mem_ready`=1 → state sequences 0,1,6,7 and 0,1,9,10. `alu_op`=00 in EXEC_R, 11 in EXEC_I. `reg_dst`=1 only in WB_R. `instr_count`=2 after 8 cycles.
- lw with `mem_ready` low for 3 cycles in MEMRD → MEMRD held 4 cycles, `mem_req`/`i_or_d` stable throughout, then WB_MEM with `mem_to_reg`=1. Total 8 cycles.
- beq, sw, j back-to-back, `mem_ready`=1 → `branch`=1 with `pc_src`=01 in BRANCH. `mem_we`=1 only in MEMWR. `pc_src`=10 in JUMP. `instr_count`=3.
- Opcode 111000, then halt → `illegal_op` pulses 1 cycle and FSM returns to FETCH. `halted`=1 persists for 20 cycles. `instr_count` unchanged.
- `rst` asserted while in MEMRD waiting on `mem_ready` → `mem_req`=0 in the reset cycle, then FETCH, `instr_count`=0.
